// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter and its helpers.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SEND,
        WAIT_IDLE,
        DONE,
        ERROR
    } state_t;

    localparam int unsigned FRAME_FALLS = 11;
    localparam int unsigned ACK_FALL    = 11;
    localparam int unsigned STOP_FALL   = 10;
    localparam int unsigned PARITY_FALL = 9;

    // Parity bit that makes data plus parity hold an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// kclk synchroniser, stability filter and falling-edge strobe.
module ps2_clk_filter #(
    parameter int unsigned FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic kclk,
    output logic kclk_filt,
    output logic fall
);

    localparam int unsigned CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

    logic             meta;
    logic             kclk_sync;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta       <= 1'b1;
            kclk_sync  <= 1'b1;
            kclk_filt  <= 1'b1;
            stable_cnt <= '0;
            fall       <= 1'b0;
        end else begin
            meta      <= kclk;
            kclk_sync <= meta;
            fall      <= 1'b0;
            // A new level is taken only after FILTER_CYCLES consecutive differing samples.
            if (kclk_sync == kclk_filt) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(FILTER_CYCLES - 1)) begin
                kclk_filt  <= kclk_sync;
                stable_cnt <= '0;
                fall       <= kclk_filt;
            end else begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_transmitter.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, serialise, check ack.
module ps2_transmitter
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned START_CYCLES   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned FILTER_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kclk,
    input  logic       kdata,
    output logic       kclk_oe,
    output logic       kdata_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned MAX_A   = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state;
    logic [7:0]       data;
    logic             parity;
    logic [3:0]       bit_cnt;
    logic [3:0]       bit_next;
    logic [CNT_W-1:0] cnt;
    logic             kdata_meta;
    logic             kdata_sync;
    logic             kclk_filt;
    logic             fall;
    logic             timed_out;

    ps2_clk_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_clk_filter (
        .clk       (clk),
        .rst       (rst),
        .kclk      (kclk),
        .kclk_filt (kclk_filt),
        .fall      (fall)
    );

    assign bit_next  = bit_cnt + 4'd1;
    assign timed_out = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            kclk_oe    <= 1'b0;
            kdata_oe   <= 1'b0;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            data       <= '0;
            parity     <= 1'b0;
            bit_cnt    <= '0;
            cnt        <= '0;
            kdata_meta <= 1'b1;
            kdata_sync <= 1'b1;
        end else begin
            kdata_meta <= kdata;
            kdata_sync <= kdata_meta;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        data     <= tx_data;
                        parity   <= odd_parity(tx_data);
                        bit_cnt  <= '0;
                        cnt      <= '0;
                        kclk_oe  <= 1'b1;
                        tx_ready <= 1'b0;
                        tx_busy  <= 1'b1;
                        state    <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                        cnt      <= '0;
                        kdata_oe <= 1'b1;
                        state    <= START;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                START: begin
                    if (cnt == CNT_W'(START_CYCLES - 1)) begin
                        cnt     <= '0;
                        kclk_oe <= 1'b0;
                        state   <= SEND;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SEND: begin
                    if (fall) begin
                        cnt     <= '0;
                        bit_cnt <= bit_next;
                        // bit_cnt still holds the previous fall count, so it indexes d[fall-1].
                        if (bit_next == 4'(ACK_FALL)) begin
                            if (!kdata_sync) begin
                                state <= WAIT_IDLE;
                            end else begin
                                kdata_oe <= 1'b0;
                                tx_error <= 1'b1;
                                state    <= ERROR;
                            end
                        end else if (bit_next == 4'(STOP_FALL)) begin
                            kdata_oe <= 1'b0;
                        end else if (bit_next == 4'(PARITY_FALL)) begin
                            kdata_oe <= ~parity;
                        end else begin
                            kdata_oe <= ~data[bit_cnt[2:0]];
                        end
                    end else if (timed_out) begin
                        kclk_oe  <= 1'b0;
                        kdata_oe <= 1'b0;
                        tx_error <= 1'b1;
                        state    <= ERROR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (kclk_filt && kdata_sync) begin
                        tx_done <= 1'b1;
                        state   <= DONE;
                    end else if (fall) begin
                        cnt <= '0;
                    end else if (timed_out) begin
                        kclk_oe  <= 1'b0;
                        kdata_oe <= 1'b0;
                        tx_error <= 1'b1;
                        state    <= ERROR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE, ERROR: begin
                    kclk_oe  <= 1'b0;
                    kdata_oe <= 1'b0;
                    tx_ready <= 1'b1;
                    tx_busy  <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_transmitter.sv
// Directed bench for ps2_transmitter with an open-drain bus and a simple device model.
module tb_ps2_transmitter;

    localparam int unsigned INH  = 40;
    localparam int unsigned STC  = 6;
    localparam int unsigned TMO  = 300;
    localparam int unsigned FLT  = 4;
    localparam int          HALF = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       kclk;
    logic       kdata;
    logic       kclk_oe;
    logic       kdata_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic       dev_kclk_low  = 1'b0;
    logic       dev_kdata_low = 1'b0;

    assign kclk  = ~(kclk_oe | dev_kclk_low);
    assign kdata = ~(kdata_oe | dev_kdata_low);

    ps2_transmitter #(
        .INHIBIT_CYCLES (INH),
        .START_CYCLES   (STC),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_CYCLES  (FLT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .kclk     (kclk),
        .kdata    (kdata),
        .kclk_oe  (kclk_oe),
        .kdata_oe (kdata_oe),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_error (tx_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_tot = 0;
    int err_tot  = 0;
    int inh_tot  = 0;
    int st_tot   = 0;

    always @(negedge clk) begin
        done_tot <= done_tot + int'(tx_done);
        err_tot  <= err_tot + int'(tx_error);
        inh_tot  <= inh_tot + int'(kclk_oe && !kdata_oe);
        st_tot   <= st_tot + int'(kclk_oe && kdata_oe);
    end

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       parity;
        int         done;
        int         err;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rst_midframe_check();
        rst = 1'b1;
        @(negedge clk);
        check("rst_kclk_oe", kclk_oe, 0);
        check("rst_kdata_oe", kdata_oe, 0);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_error", tx_error, 0);
        rst = 1'b0;
        dev_kclk_low = 1'b0;
    endtask

    // Device side: waits for request-to-send, generates 11 clocks, captures host bits.
    task automatic device(input logic ack, input int glitch_after, input int rst_after,
                          output logic [10:0] cap);
        int n;
        cap = '0;
        n = 0;
        while (!(kclk_oe && kdata_oe) && n < 2000) begin @(negedge clk); n++; end
        check("start_reached", n < 2000, 1);
        n = 0;
        while (kclk_oe && n < 2000) begin @(negedge clk); n++; end
        check("send_reached", n < 2000, 1);
        repeat (HALF) @(negedge clk);
        cap[0] = kdata;
        for (int i = 1; i <= 11; i++) begin
            if (i == 11 && ack) dev_kdata_low = 1'b1;
            dev_kclk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (i == rst_after) begin
                rst_midframe_check();
                return;
            end
            dev_kclk_low = 1'b0;
            if (i == glitch_after) begin
                repeat (8) @(negedge clk);
                dev_kclk_low = 1'b1;
                repeat (3) @(negedge clk);
                dev_kclk_low = 1'b0;
                repeat (HALF - 11) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            if (i <= 10) cap[i] = kdata;
        end
        dev_kdata_low = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int glitch_after, input logic inject, input string tag);
        int d0, e0, i0, s0, n;
        logic [10:0] cap;
        @(negedge clk);
        d0 = done_tot; e0 = err_tot; i0 = inh_tot; s0 = st_tot;
        tx_data  = v.data;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        if (inject) begin
            repeat (10) @(negedge clk);
            tx_data  = 8'h55;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
        end
        device(v.ack, glitch_after, 0, cap);
        n = 0;
        while (!tx_ready && n < 500) begin @(negedge clk); n++; end
        check({tag, "_ready_back"}, n < 500, 1);
        repeat (5) @(negedge clk);
        check({tag, "_start_bit"}, cap[0], 0);
        check({tag, "_data"}, cap[8:1], v.data);
        check({tag, "_parity"}, cap[9], v.parity);
        check({tag, "_stop"}, cap[10], 1);
        check({tag, "_done_cnt"}, done_tot - d0, v.done);
        check({tag, "_err_cnt"}, err_tot - e0, v.err);
        check({tag, "_inhibit_len"}, inh_tot - i0, INH);
        check({tag, "_start_len"}, st_tot - s0, STC);
        check({tag, "_kclk_oe_idle"}, kclk_oe, 0);
        check({tag, "_kdata_oe_idle"}, kdata_oe, 0);
        if (inject) begin
            repeat (100) @(negedge clk);
            check({tag, "_no_queued_busy"}, tx_busy, 0);
            check({tag, "_no_queued_done"}, done_tot - d0, v.done);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, d0, e0;
        logic [10:0] cap;
        vec_t glitch_v, f4_v;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 1, 0};
        vecs[1] = '{8'h01, 1'b1, 1'b0, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1, 0};
        vecs[3] = '{8'hA5, 1'b0, 1'b1, 0, 1};
        vecs[4] = '{8'hF4, 1'b1, 1'b0, 1, 0};
        glitch_v = '{8'hED, 1'b1, 1'b1, 1, 0};
        f4_v     = '{8'hF4, 1'b1, 1'b0, 1, 0};

        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_kclk_oe", kclk_oe, 0);
        check("reset_kdata_oe", kdata_oe, 0);
        check("reset_ready", tx_ready, 1);
        check("reset_busy", tx_busy, 0);
        check("reset_done", tx_done, 0);
        check("reset_error", tx_error, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], 0, 1'b0, $sformatf("vec%0d", i));
        end

        // Ignored request while busy, plus a sub-filter kclk glitch after fall 3.
        run_vec(glitch_v, 3, 1'b1, "glitch");

        // Device never clocks: timeout measured from SEND entry.
        @(negedge clk);
        d0 = done_tot;
        tx_data = 8'h3C; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (!(kclk_oe && kdata_oe) && n < 2000) begin @(negedge clk); n++; end
        check("to_start_reached", n < 2000, 1);
        n = 0;
        while (kclk_oe && n < 2000) begin @(negedge clk); n++; end
        check("to_send_reached", n < 2000, 1);
        n = 0;
        while (!tx_error && n < int'(TMO) + 50) begin @(negedge clk); n++; end
        check("to_latency", n, TMO);
        check("to_kdata_oe", kdata_oe, 0);
        check("to_kclk_oe", kclk_oe, 0);
        @(negedge clk);
        check("to_error_one_cycle", tx_error, 0);
        check("to_ready_back", tx_ready, 1);
        check("to_no_done", done_tot - d0, 0);

        // Reset at fall 5 of 0xED, then a clean 0xF4 transfer.
        @(negedge clk);
        d0 = done_tot; e0 = err_tot;
        tx_data = 8'hED; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        device(1'b1, 0, 5, cap);
        repeat (50) @(negedge clk);
        check("midrst_no_done", done_tot - d0, 0);
        check("midrst_no_error", err_tot - e0, 0);
        check("midrst_ready", tx_ready, 1);
        run_vec(f4_v, 0, 1'b0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
